uart_stream_scheduler: RTL and testbench

Sequences audio samples onto the shared UART byte transmitter. Accepts either the beamformed delay-sum-shift stream (single mode) or the raw two-mic TDM stream (dual mode, decimated 2:1). Buffers samples in a small FIFO and issues one trigger per frame to the transmitter, honouring its busy handshake. Counts samples dropped on overflow. Sits between `tdm_receive`/`delay_bram` and `uart_byte_transmit`; replaces the ad-hoc waiting-sample logic in the top level.

---
 rtl/uart_stream_scheduler_if.sv | 36 +++
 rtl/uart_stream_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_uart_stream_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_stream_scheduler_if.sv
// Stream-side inputs and transmitter-side handshake of uart_stream_scheduler.
// The master modport drives the audio strobes and transmitter busy.
// The slave modport is the scheduler itself.
interface uart_stream_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             enable_in;
    logic             mode_in;
    logic [23:0]      dss_audio_in;
    logic             dss_valid_in;
    logic [23:0]      mic0_in;
    logic [23:0]      mic1_in;
    logic             mic_valid_in;
    logic             uart_busy_in;
    logic [31:0]      uart_data_out;
    logic             uart_dual_out;
    logic             uart_trigger_out;
    logic [LVL_W-1:0] fifo_level_out;
    logic [15:0]      dropped_count_out;

    modport master (
        output enable_in, mode_in, dss_audio_in, dss_valid_in,
               mic0_in, mic1_in, mic_valid_in, uart_busy_in,
        input  uart_data_out, uart_dual_out, uart_trigger_out,
               fifo_level_out, dropped_count_out
    );

    modport slave (
        input  enable_in, mode_in, dss_audio_in, dss_valid_in,
               mic0_in, mic1_in, mic_valid_in, uart_busy_in,
        output uart_data_out, uart_dual_out, uart_trigger_out,
               fifo_level_out, dropped_count_out
    );
endinterface

// File: rtl/uart_stream_scheduler.sv
// Audio sample scheduler for the shared UART byte transmitter.
// Frames come from either the beamformed stream (single mode) or from the two raw mics decimated 2:1 (dual mode).
// Frames are buffered in a small FIFO.
// Each frame is launched with a one-cycle trigger that honours the transmitter busy handshake.
module uart_stream_scheduler #(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    uart_stream_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q;
    logic             mode_q, enable_q, toggle_q;
    logic [32:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [15:0]      dropped_q;
    logic             trigger_q, dual_q;
    logic [31:0]      data_q;

    logic             mode_chg_s, flush_s, full_s, empty_s;
    logic             push_req_s, push_s, accept_s, drop_s, launch_s;
    logic [32:0]      frame_s, head_s;
    logic             unused_bits_s;

    // The low audio byte never reaches the transmitter
    assign unused_bits_s = ^{bus.dss_audio_in[7:0], bus.mic0_in[7:0], bus.mic1_in[7:0]};

    assign mode_chg_s = bus.mode_in ^ mode_q;
    // A mode switch or an enable fall discards everything buffered. The in-flight frame is untouched.
    assign flush_s    = mode_chg_s | (enable_q & ~bus.enable_in);
    assign full_s     = (level_q == LVL_FULL);
    assign empty_s    = (level_q == {LVL_W{1'b0}});
    assign head_s     = mem_q[rd_ptr_q];

    // Remember last mode/enable so switches and enable falls can be detected.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            mode_q   <= bus.mode_in;
            enable_q <= bus.enable_in;
        end
    end

    // Dual-mode decimation toggle. Only every second mic strobe forms a frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            toggle_q <= 1'b0;
        end else if (mode_chg_s) begin
            toggle_q <= 1'b0;
        end else if (bus.mode_in && bus.mic_valid_in) begin
            toggle_q <= ~toggle_q;
        end
    end

    // Frame formation and push request from whichever stream the mode selects.
    always_comb begin
        push_req_s = 1'b0;
        frame_s    = 33'd0;
        if (!bus.mode_in) begin
            push_req_s = bus.dss_valid_in;
            frame_s    = {1'b0, 16'h0000, bus.dss_audio_in[23:8]};
        end else begin
            push_req_s = bus.mic_valid_in & toggle_q;
            frame_s    = {1'b1, bus.mic1_in[23:8], bus.mic0_in[23:8]};
        end
        push_s = push_req_s & bus.enable_in & ~flush_s;
    end

    // Launch FSM outputs. A pop on the same edge frees a slot for a push at full.
    always_comb begin
        launch_s = 1'b0;
        if ((state_q == ST_IDLE) && !empty_s && !flush_s) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
        accept_s = push_s & (~full_s | launch_s);
        drop_s   = push_s & full_s & ~launch_s;
    end

    // Launch FSM next state. A busy that never rises is given up after BUSY_TIMEOUT cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) state_d = ST_WAIT_BUSY;
                else          state_d = ST_IDLE;
            end
            ST_WAIT_BUSY: begin
                if (bus.uart_busy_in)       state_d = ST_WAIT_DONE;
                else if (tmr_q == TMR_LAST) state_d = ST_IDLE;
                else                        state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_DONE: begin
                if (!bus.uart_busy_in) state_d = ST_IDLE;
                else                   state_d = ST_WAIT_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Launch FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Count cycles spent waiting for busy to rise.
    always_ff @(posedge clk_in) begin
        if (rst_in)                      tmr_q <= {TMR_W{1'b0}};
        else if (state_q == ST_WAIT_BUSY) tmr_q <= tmr_q + TMR_W'(1);
        else                             tmr_q <= {TMR_W{1'b0}};
    end

    // FIFO storage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 33'd0;
        end else if (accept_s) begin
            mem_q[wr_ptr_q] <= frame_s;
        end
    end

    // FIFO pointers and occupancy. A flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_s) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            if (accept_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (launch_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(accept_s) - LVL_W'(launch_s);
        end
    end

    // Saturating count of frames lost to a full FIFO. It survives flushes.
    always_ff @(posedge clk_in) begin
        if (rst_in)                           dropped_q <= 16'h0000;
        else if (drop_s && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'h0001;
    end

    // Registered trigger pulse. The payload holds until the next launch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            trigger_q <= 1'b0;
            data_q    <= 32'h0000_0000;
            dual_q    <= 1'b0;
        end else begin
            trigger_q <= launch_s;
            if (launch_s) begin
                data_q <= head_s[31:0];
                dual_q <= head_s[32];
            end
        end
    end

    assign bus.uart_trigger_out  = trigger_q;
    assign bus.uart_data_out     = data_q;
    assign bus.uart_dual_out     = dual_q;
    assign bus.fifo_level_out    = level_q;
    assign bus.dropped_count_out = dropped_q;
endmodule

// File: tb/tb_uart_stream_scheduler.sv
// Scoreboard bench for uart_stream_scheduler.
// The stimulus pushes expected frames into a queue.
// An independent monitor pops from the queue and compares on every trigger.
module tb_uart_stream_scheduler;
    localparam int D  = 4;
    localparam int BT = 8;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    uart_stream_scheduler_if #(.FIFO_DEPTH(D)) bus ();

    uart_stream_scheduler #(.FIFO_DEPTH(D), .BUSY_TIMEOUT(BT)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          trig_count = 0;
    int          trig_cyc_q[$];
    logic [32:0] exp_q[$];
    int          busy_len = 0;
    bit          busy_rand = 1'b0;
    bit          m_mode = 1'b0;
    bit          m_en = 1'b1;
    bit          m_tog = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every trigger must match the oldest expected frame
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && bus.uart_trigger_out === 1'b1) begin
                trig_count++;
                trig_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trigger: actual=%0h required=no_trigger", bus.uart_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", bus.uart_data_out, e[31:0]);
                    check("frame_dual", bus.uart_dual_out, e[32]);
                end
            end
        end
    end

    // Transmitter model: raises busy right after a trigger for a chosen number of cycles
    initial begin
        int len;
        bus.uart_busy_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!rst_in && bus.uart_trigger_out === 1'b1) begin
                len = busy_rand ? int'($urandom_range(1, 6)) : busy_len;
                if (len > 0) begin
                    bus.uart_busy_in = 1'b1;
                    for (int k = 0; k < len && !rst_in; k++) @(negedge clk_in);
                    bus.uart_busy_in = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic strobe_dss(input logic [23:0] d, input bit exp_it);
        if (exp_it) exp_q.push_back({1'b0, 16'h0000, d[23:8]});
        bus.dss_audio_in = d;
        bus.dss_valid_in = 1'b1;
        @(negedge clk_in);
        bus.dss_valid_in = 1'b0;
    endtask

    task automatic strobe_mic(input logic [23:0] m0, input logic [23:0] m1, input bit exp_it);
        if (exp_it) exp_q.push_back({1'b1, m1[23:8], m0[23:8]});
        bus.mic0_in      = m0;
        bus.mic1_in      = m1;
        bus.mic_valid_in = 1'b1;
        @(negedge clk_in);
        bus.mic_valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        while (bus.uart_busy_in === 1'b1 && n < 20000) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL %s_drain: actual=%0d_pending required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (BT + 4) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_trigger"}, bus.uart_trigger_out, 0);
        check({name, "_data"}, bus.uart_data_out, 0);
        check({name, "_dual"}, bus.uart_dual_out, 0);
        check({name, "_level"}, bus.fifo_level_out, 0);
        check({name, "_dropped"}, bus.dropped_count_out, 0);
    endtask

    initial begin
        int t0;
        int sp;
        int n;
        bit kind;
        bit exp_it;
        logic [23:0] d0;
        logic [23:0] d1;

        bus.enable_in    = 1'b1;
        bus.mode_in      = 1'b0;
        bus.dss_audio_in = 24'h000000;
        bus.dss_valid_in = 1'b0;
        bus.mic0_in      = 24'h000000;
        bus.mic1_in      = 24'h000000;
        bus.mic_valid_in = 1'b0;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_all_zero("reset");

        // Single frame: level next cycle, trigger two cycles after the strobe
        busy_len = 0;
        t0 = trig_count;
        exp_q.push_back({1'b0, 32'h0000_1234});
        bus.dss_audio_in = 24'h123456;
        bus.dss_valid_in = 1'b1;
        @(negedge clk_in);
        bus.dss_valid_in = 1'b0;
        check("t1_level", bus.fifo_level_out, 1);
        check("t1_trig_early", bus.uart_trigger_out, 0);
        @(negedge clk_in);
        check("t1_trig", bus.uart_trigger_out, 1);
        check("t1_data", bus.uart_data_out, 32'h0000_1234);
        check("t1_dual", bus.uart_dual_out, 0);
        @(negedge clk_in);
        check("t1_trig_pulse", bus.uart_trigger_out, 0);
        wait_drain("t1");
        check("t1_count", trig_count - t0, 1);

        // Dual mode: only the 2nd and 4th strobes form frames
        bus.mode_in = 1'b1;
        repeat (2) @(negedge clk_in);
        busy_len = 3;
        t0 = trig_count;
        strobe_mic(24'hAAAA00, 24'hBBBB00, 1'b0);
        repeat (20) @(negedge clk_in);
        strobe_mic(24'h111100, 24'h222200, 1'b1);
        repeat (20) @(negedge clk_in);
        strobe_mic(24'h333300, 24'h444400, 1'b0);
        repeat (20) @(negedge clk_in);
        strobe_mic(24'h555500, 24'h666600, 1'b1);
        wait_drain("t2");
        check("t2_count", trig_count - t0, 2);

        // Overflow: 1 in flight plus D buffered, the last two strobes are dropped
        bus.mode_in = 1'b0;
        repeat (2) @(negedge clk_in);
        busy_len = 1000;
        t0 = trig_count;
        for (int i = 0; i < D + 3; i++) strobe_dss({8'hC0, 8'(i), 8'h77}, i <= D);
        check("t3_dropped", bus.dropped_count_out, 2);
        check("t3_level", bus.fifo_level_out, D);
        wait_drain("t3");
        check("t3_count", trig_count - t0, D + 1);

        // Mode flip with 3 buffered: flushed, in-flight completes, toggle restarts
        busy_len = 200;
        t0 = trig_count;
        for (int i = 0; i < 4; i++) strobe_dss({8'h5E, 8'(i), 8'h00}, i == 0);
        repeat (3) @(negedge clk_in);
        check("t4_level_before", bus.fifo_level_out, 3);
        bus.mode_in = 1'b1;
        @(negedge clk_in);
        check("t4_level_flushed", bus.fifo_level_out, 0);
        check("t4_dropped_kept", bus.dropped_count_out, 2);
        wait_drain("t4");
        check("t4_count", trig_count - t0, 1);
        busy_len = 3;
        t0 = trig_count;
        strobe_mic(24'h0F0F00, 24'hF0F000, 1'b0);
        repeat (30) @(negedge clk_in);
        check("t4_no_trig", trig_count - t0, 0);
        strobe_mic(24'h123400, 24'h567800, 1'b1);
        wait_drain("t4b");
        check("t4b_count", trig_count - t0, 1);

        // Busy never rises: timeout then the next buffered frame launches
        bus.mode_in = 1'b0;
        repeat (2) @(negedge clk_in);
        busy_len = 0;
        trig_cyc_q.delete();
        t0 = trig_count;
        strobe_dss(24'hABCDEF, 1'b1);
        strobe_dss(24'h765432, 1'b1);
        wait_drain("t5");
        check("t5_count", trig_count - t0, 2);
        if (trig_cyc_q.size() >= 2) begin
            sp = trig_cyc_q[1] - trig_cyc_q[0];
            checks++;
            if (sp < BT || sp > BT + 3) begin
                errors++;
                $display("FAIL t5_spacing: actual=%0d required=%0d..%0d", sp, BT, BT + 3);
            end
        end

        // Reset during WAIT_DONE with 2 buffered
        busy_len = 1000;
        t0 = trig_count;
        for (int i = 0; i < 3; i++) strobe_dss({8'h3C, 8'(i), 8'h11}, i == 0);
        repeat (5) @(negedge clk_in);
        check("t6_level_before", bus.fifo_level_out, 2);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_all_zero("t6_reset");
        rst_in = 1'b0;
        repeat (50) @(negedge clk_in);
        check("t6_count", trig_count - t0, 1);
        check("t6_no_pending", exp_q.size(), 0);
        busy_len = 3;
        t0 = trig_count;
        strobe_dss(24'h4321AA, 1'b1);
        wait_drain("t6b");
        check("t6b_count", trig_count - t0, 1);

        // Randomized bursts against the frame-formation model
        busy_rand = 1'b1;
        m_mode = 1'b0;
        m_tog = 1'b0;
        m_en = 1'b1;
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_mode = ~m_mode;
                m_tog = 1'b0;
                bus.mode_in = m_mode;
                repeat (2) @(negedge clk_in);
            end
            m_en = ($urandom_range(0, 4) != 0);
            if (bus.enable_in != m_en) begin
                bus.enable_in = m_en;
                repeat (2) @(negedge clk_in);
            end
            n = int'($urandom_range(1, D));
            for (int j = 0; j < n; j++) begin
                kind = 1'($urandom_range(0, 1));
                if (m_mode && !m_en) kind = 1'b0;
                d0 = 24'($urandom);
                d1 = 24'($urandom);
                if (!kind) begin
                    exp_it = !m_mode && m_en;
                    strobe_dss(d0, exp_it);
                end else begin
                    exp_it = m_mode && m_en && m_tog;
                    if (m_mode) m_tog = ~m_tog;
                    strobe_mic(d0, d1, exp_it);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk_in);
            end
            wait_drain("rand");
        end
        check("rand_dropped", bus.dropped_count_out, 0);
        check("rand_level", bus.fifo_level_out, 0);
        busy_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
